// File: rtl/avsd_pll_lock_det.sv
// avsd_pll_lock_det
//   Lock detector for the avsd_pll_1v8 PLL. Runs on the PLL output clock,
//   measures CLK cycles per REF period and declares lock once the ratio
//   has held within MULT +/- TOL for LOCK_CNT consecutive windows.
// Ports
//   CLK       in   PLL output clock (only clock)
//   RST_N     in   asynchronous active-low reset
//   EN_VCO    in   PLL enable, synchronous level; low forces IDLE
//   REF       in   reference clock, asynchronous to CLK
//   LOCK      out  lock indication
//   CNT_VALID out  one-cycle pulse when a window count is published
//   MEAS_CNT  out  last published window count
//   FREQ_ERR  out  MEAS_CNT - MULT, two's complement, CW+1 bits
//   REF_LOST  out  sticky: no REF edge within 2^CW-1 cycles
module avsd_pll_lock_det #(
  parameter int unsigned MULT       = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned CW         = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN_VCO,
  input  logic                 REF,
  output logic                 LOCK,
  output logic                 CNT_VALID,
  output logic [CW-1:0]        MEAS_CNT,
  output logic signed [CW:0]   FREQ_ERR,
  output logic                 REF_LOST
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW:0]   MULT_X   = (CW+1)'(MULT);
  localparam logic [CW:0]   TOL_X    = (CW+1)'(TOL);
  localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_N = BW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_TRACK,
    ST_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      good_q, good_d;
  logic [BW-1:0]      bad_q, bad_d;
  logic               lock_q, lock_d;
  logic               valid_q, valid_d;
  logic [CW-1:0]      meas_q, meas_d;
  logic signed [CW:0] ferr_q, ferr_d;
  logic               lost_q, lost_d;

  logic               ref_edge;
  logic [CW:0]        err_u;
  logic [CW:0]        abs_err;
  logic               win_good;
  logic [GW-1:0]      good_inc;
  logic [BW-1:0]      bad_inc;

  assign ref_edge = s2_q & ~s3_q;

  // Deviation of the pre-load count from the nominal ratio.
  assign err_u    = {1'b0, cnt_q} - MULT_X;
  assign abs_err  = err_u[CW] ? (MULT_X - {1'b0, cnt_q}) : err_u;
  assign win_good = (abs_err <= TOL_X);

  assign good_inc = (good_q == LOCK_N)   ? good_q : good_q + GW'(1);
  assign bad_inc  = (bad_q  == UNLOCK_N) ? bad_q  : bad_q  + BW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      meas_q  <= '0;
      ferr_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= REF;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      meas_q  <= meas_d;
      ferr_q  <= ferr_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    lock_d  = lock_q;
    valid_d = 1'b0;
    meas_d  = meas_q;
    ferr_d  = ferr_q;
    lost_d  = lost_q;

    if (ref_edge) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!EN_VCO) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      good_d  = '0;
      bad_d   = '0;
      lock_d  = 1'b0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          good_d  = '0;
          bad_d   = '0;
          lock_d  = 1'b0;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          // First edge only arms the counter; no window is published.
          if (ref_edge) begin
            state_d = ST_TRACK;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          // An edge on the saturation cycle takes priority over the timeout.
          if (ref_edge) begin
            valid_d = 1'b1;
            meas_d  = cnt_q;
            ferr_d  = $signed(err_u);
            if (win_good) begin
              lost_d = 1'b0;
            end
            if (state_q == ST_TRACK) begin
              if (win_good) begin
                if (good_inc == LOCK_N) begin
                  state_d = ST_LOCKED;
                  lock_d  = 1'b1;
                  good_d  = '0;
                  bad_d   = '0;
                end else begin
                  good_d = good_inc;
                end
              end else begin
                good_d = '0;
              end
            end else begin
              if (!win_good) begin
                if (bad_inc == UNLOCK_N) begin
                  state_d = ST_TRACK;
                  lock_d  = 1'b0;
                  good_d  = '0;
                  bad_d   = '0;
                end else begin
                  bad_d = bad_inc;
                end
              end else begin
                bad_d = '0;
              end
            end
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_ACQUIRE;
            lost_d  = 1'b1;
            lock_d  = 1'b0;
            good_d  = '0;
            bad_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign LOCK      = lock_q;
  assign CNT_VALID = valid_q;
  assign MEAS_CNT  = meas_q;
  assign FREQ_ERR  = ferr_q;
  assign REF_LOST  = lost_q;

endmodule

// File: tb/tb_avsd_pll_lock_det.sv
// tb_avsd_pll_lock_det
//   Self-checking bench for avsd_pll_lock_det. REF is driven synchronously
//   to CLK so each window length in cycles is known exactly; a window-level
//   reference model predicts every published count, LOCK and REF_LOST.
module tb_avsd_pll_lock_det;

  localparam int unsigned MULT       = 8;
  localparam int unsigned TOL        = 1;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned UNLOCK_CNT = 2;
  localparam int unsigned CW         = 8;
  localparam int unsigned CNT_MAX    = (1 << CW) - 1;
  // REF rise to counter reload through the synchroniser.
  localparam int unsigned SYNC_LAT   = 3;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 EN_VCO = 1'b0;
  logic                 REF = 1'b0;
  logic                 LOCK;
  logic                 CNT_VALID;
  logic [CW-1:0]        MEAS_CNT;
  logic signed [CW:0]   FREQ_ERR;
  logic                 REF_LOST;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned meas;
    int          err;
    bit          lock;
    bit          lost;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Window-level model state.
  bit          m_armed;
  bit          m_lock;
  bit          m_lost;
  int unsigned m_good;
  int unsigned m_bad;
  int unsigned last_rise;

  avsd_pll_lock_det #(
    .MULT       (MULT),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .CW         (CW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN_VCO    (EN_VCO),
    .REF       (REF),
    .LOCK      (LOCK),
    .CNT_VALID (CNT_VALID),
    .MEAS_CNT  (MEAS_CNT),
    .FREQ_ERR  (FREQ_ERR),
    .REF_LOST  (REF_LOST)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_armed = 1'b0;
    m_lock  = 1'b0;
    m_lost  = 1'b0;
    m_good  = 0;
    m_bad   = 0;
  endtask

  task automatic model_timeout();
    m_lost  = 1'b1;
    m_lock  = 1'b0;
    m_good  = 0;
    m_bad   = 0;
    m_armed = 1'b0;
  endtask

  // Apply a reference loss that has become visible by now.
  task automatic model_settle();
    if (m_armed && (cyc - last_rise >= CNT_MAX + SYNC_LAT)) model_timeout();
  endtask

  // Called at each REF rising edge with p = cycles since the previous one.
  task automatic model_rise();
    int unsigned p;
    int          d;
    bit          g;
    p = cyc - last_rise;
    last_rise = cyc;
    check("missing_valid", exp_q.size(), 0);
    if (m_armed && p > CNT_MAX) model_timeout();
    if (!m_armed) begin
      m_armed = 1'b1;
      return;
    end
    d = int'(p) - int'(MULT);
    g = (d <= int'(TOL)) && (d >= -int'(TOL));
    if (g) m_lost = 1'b0;
    if (!m_lock) begin
      if (g) begin
        m_good++;
        if (m_good == LOCK_CNT) begin
          m_lock = 1'b1;
          m_bad  = 0;
        end
      end else begin
        m_good = 0;
      end
    end else begin
      if (!g) begin
        m_bad++;
        if (m_bad == UNLOCK_CNT) begin
          m_lock = 1'b0;
          m_good = 0;
          m_bad  = 0;
        end
      end else begin
        m_bad = 0;
      end
    end
    exp_q.push_back('{p, d, m_lock, m_lost});
  endtask

  always @(negedge CLK) begin
    if (RST_N && CNT_VALID !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", CNT_VALID, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("meas_cnt", MEAS_CNT, mon_e.meas);
        check("freq_err", FREQ_ERR, mon_e.err);
        check("lock_at_valid", LOCK, mon_e.lock);
        check("ref_lost_at_valid", REF_LOST, mon_e.lost);
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One REF period of p CLK cycles, starting with the rising edge.
  task automatic win(input int unsigned p);
    @(posedge CLK);
    #1;
    REF = 1'b1;
    model_rise();
    repeat (p / 2) begin
      @(posedge CLK);
      #1;
    end
    REF = 1'b0;
    repeat (p - p / 2 - 1) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic disable_pll();
    idle(3);
    EN_VCO = 1'b0;
    model_clear();
    idle(2);
    check("dis_lock", LOCK, m_lock);
    check("dis_ref_lost", REF_LOST, m_lost);
    check("dis_valid", CNT_VALID, 0);
    EN_VCO = 1'b1;
    idle(3);
  endtask

  task automatic reset_mid();
    idle(3);
    #3;
    RST_N = 1'b0;
    model_clear();
    #1;
    check("rst_mid_lock", LOCK, 0);
    check("rst_mid_valid", CNT_VALID, 0);
    check("rst_mid_meas", MEAS_CNT, 0);
    check("rst_mid_ferr", FREQ_ERR, 0);
    check("rst_mid_lost", REF_LOST, 0);
    idle(2);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(3);
  endtask

  function automatic int unsigned pick_period();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 10)       return 8;
    else if (r < 12)  return 7;
    else if (r < 14)  return 9;
    else if (r == 14) return 6;
    else if (r == 15) return 10;
    else if (r == 16) return 11;
    else if (r == 17) return $urandom_range(4, 24);
    else if (r == 18) return $urandom_range(250, 262);
    else              return $urandom_range(12, 40);
  endfunction

  initial begin
    model_clear();
    EN_VCO = 1'b1;
    REF    = 1'b0;
    RST_N  = 1'b0;
    idle(3);
    check("rst_lock", LOCK, 0);
    check("rst_valid", CNT_VALID, 0);
    check("rst_meas", MEAS_CNT, 0);
    check("rst_ferr", FREQ_ERR, 0);
    check("rst_lost", REF_LOST, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(3);
    last_rise = cyc;

    // Ideal ratio: lock on the 4th published window.
    repeat (6) win(8);
    check("ideal_lock", LOCK, m_lock);

    // Tolerance boundary.
    disable_pll();
    repeat (6) win(9);
    check("tol9_lock", LOCK, m_lock);
    disable_pll();
    repeat (7) win(10);
    check("tol10_lock", LOCK, m_lock);
    disable_pll();
    repeat (7) win(6);
    check("tol6_lock", LOCK, m_lock);

    // Unlock: a lone bad window is tolerated, two in a row drop LOCK.
    disable_pll();
    repeat (6) win(8);
    win(11);
    win(8);
    win(11);
    win(11);
    win(8);
    check("unlock_lock", LOCK, m_lock);
    repeat (5) win(8);

    // Reference loss, then recovery.
    win(300);
    model_settle();
    check("loss_ref_lost", REF_LOST, m_lost);
    check("loss_lock", LOCK, m_lock);
    repeat (6) win(8);
    check("relock_lock", LOCK, m_lock);
    check("relock_lost", REF_LOST, m_lost);

    // Edge on the saturation cycle, then the first timing-out length.
    win(255);
    win(8);
    check("sim_edge_lost", REF_LOST, m_lost);
    repeat (5) win(8);
    win(256);
    win(8);
    model_settle();
    check("t256_lost", REF_LOST, m_lost);
    repeat (6) win(8);

    // Asynchronous reset while locked.
    reset_mid();
    repeat (6) win(8);
    check("post_rst_lock", LOCK, m_lock);

    // Randomised windows with occasional disable or reset.
    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      r = $urandom_range(0, 39);
      if (r == 0)      disable_pll();
      else if (r == 1) reset_mid();
      win(pick_period());
    end
    win(8);
    idle(6);
    model_settle();
    check("final_lock", LOCK, m_lock);
    check("final_lost", REF_LOST, m_lost);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avsd_pll_lock_det.md
# avsd_pll_lock_det

PLL lock detector that sits directly downstream of the `avsd_pll_1v8` analog PLL model. It is clocked by the PLL output `CLK` and samples the asynchronous reference `REF`. In every reference period it counts PLL clock cycles, compares the count against the nominal multiplication ratio, and asserts `LOCK` once the ratio has held within tolerance for a programmable number of consecutive windows. SoC reset sequencing and the clock mux consume `LOCK`, the measurement outputs and `REF_LOST`.

## Interface
- `MULT`, 8: nominal PLL cycles per REF period.
- `TOL`, 1: allowed absolute deviation of a window count from `MULT`.
- `LOCK_CNT`, 4: consecutive good windows required to assert `LOCK`.
- `UNLOCK_CNT`, 2: consecutive bad windows required to drop `LOCK`.
- `CW`, 8: width of the window counter. The timeout fires at count 2^CW-1.

Ports:
- `CLK` in 1: PLL output clock; the only clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `EN_VCO` in 1: PLL enable, treated as a synchronous level. Low forces IDLE.
- `REF` in 1: reference clock, asynchronous to `CLK`.
- `LOCK` out 1: lock indication.
- `CNT_VALID` out 1: one-cycle pulse when a new window count is published.
- `MEAS_CNT` out CW: last window count.
- `FREQ_ERR` out CW+1, signed: `MEAS_CNT` − `MULT`.
- `REF_LOST` out 1: sticky flag meaning no REF edge arrived within the timeout.

## Operation
- **REF synchronisation:** two-flop synchroniser (s1, s2), then a third flop s3.
  - The edge pulse is `s2 & ~s3`, at most one cycle per REF rising edge.
- **Window counter `cnt`:**
  - On an edge cycle: load 1.
  - Otherwise: increment, saturating at 2^CW-1.
- **Published values:** on an edge cycle in TRACK or LOCKED, the count is computed from the pre-load `cnt`.
  - `MEAS_CNT` <= `cnt`.
  - `FREQ_ERR` <= `cnt` − `MULT`, as a CW+1-bit two's complement value.
  - `CNT_VALID` <= 1.
- **Window classification:** a window is good iff |`cnt` − `MULT`| <= `TOL`.
- **FSM states:** IDLE, ACQUIRE, TRACK, LOCKED.
  - **IDLE:** `cnt`, `good_cnt` and `bad_cnt` are 0 and `LOCK` = 0. Go to ACQUIRE when `EN_VCO` = 1.
  - **ACQUIRE:** the first edge arms the counter (`cnt` <= 1, nothing published) and moves the FSM to TRACK.
  - **TRACK:**
    - Good window: `good_cnt`++. When it reaches `LOCK_CNT`, go to LOCKED with `LOCK` <= 1.
    - Bad window: `good_cnt` <= 0.
  - **LOCKED:**
    - Bad window: `bad_cnt`++. When it reaches `UNLOCK_CNT`, go to TRACK with `LOCK` <= 0 and `good_cnt` <= 0.
    - Good window: `bad_cnt` <= 0.
- **Timeout:** in TRACK or LOCKED, `cnt` reaching 2^CW-1 with no edge causes:
  - `REF_LOST` <= 1, `LOCK` <= 0, transition to ACQUIRE;
  - `good_cnt` and `bad_cnt` cleared;
  - no `CNT_VALID` pulse.
- **`REF_LOST` clearing:** `REF_LOST` is cleared only by reset, by `EN_VCO` = 0, or by the next published good window.
- **`EN_VCO` = 0 in any state:** next cycle IDLE; all outputs except `MEAS_CNT` and `FREQ_ERR` clear. The PLL stops `CLK` when disabled, so this path is best-effort, and `RST_N` is the guaranteed clear.
- **Edge and timeout in the same cycle:** the edge wins. The window is published and classified, and the timeout is ignored.
- **Counter widths:** `good_cnt` and `bad_cnt` are wide enough for `LOCK_CNT` and `UNLOCK_CNT` and saturate; they never wrap.

## Timing
- **Reset values** (asynchronous assert, synchronous release on `CLK`):
  - `LOCK` = 0, `CNT_VALID` = 0, `MEAS_CNT` = 0, `FREQ_ERR` = 0, `REF_LOST` = 0;
  - FSM in IDLE; `cnt`, `good_cnt`, `bad_cnt` and s1–s3 all 0.
- **REF edge to edge pulse:** 2–3 `CLK` cycles, depending on phase.
- **Edge pulse to outputs:** `CNT_VALID`, `MEAS_CNT` and `FREQ_ERR` update on the `CLK` edge that ends the edge-pulse cycle, i.e. 1 cycle of latency.
- **`LOCK` changes:** `LOCK` rises or falls in the same cycle as the `CNT_VALID` of the deciding window.
- **Measurement jitter:** synchroniser phase uncertainty gives ±1 count. `TOL` must be >= 1.
- **Minimum lock time:** from the first REF edge, `LOCK_CNT` + 1 REF edges plus sync latency.
- **All outputs are registered.** There are no combinational input-to-output paths.

## Test plan
- **Ideal ratio:** REF period = 8×`CLK` period, `EN_VCO` = 1.
  - `MEAS_CNT` = 8 and `FREQ_ERR` = 0 on every `CNT_VALID`.
  - `LOCK` = 1 with the 4th `CNT_VALID`, i.e. at the 5th REF edge.
- **Tolerance boundary:**
  - Windows of 9 cycles: `FREQ_ERR` = +1, locks.
  - Windows of 10 cycles: `FREQ_ERR` = +2, `LOCK` stays 0.
  - Windows of 6 cycles: `FREQ_ERR` = −2, `LOCK` stays 0.
- **Unlock:** lock at 8, then two windows of 11.
  - `LOCK` falls with the 2nd `CNT_VALID`.
  - A single 11 window between good windows keeps `LOCK` = 1.
- **Reference loss:** lock, then hold REF low.
  - After 255 cycles without an edge: `REF_LOST` = 1, `LOCK` = 0, state ACQUIRE.
  - REF resumes: `REF_LOST` clears on the first good `CNT_VALID`, and `LOCK` returns after 4 good windows.
- **Reset mid-operation:** assert `RST_N` = 0 asynchronously while LOCKED, between edges.
  - All outputs go to 0 immediately.
  - After release, the first REF edge publishes nothing, and re-lock needs 4 fresh windows.
- **Simultaneous edge and timeout:** edge pulse lands on the cycle `cnt` = 255.
  - `CNT_VALID` = 1, `MEAS_CNT` = 255, bad window.
  - `REF_LOST` stays 0.
